fp_lane_collector: RTL and testbench

- Producer-side front end for the 32-lane FP reduction tree.
- Accepts a serial stream of IEEE-754 single-precision words and packs each run of N_CH words into a parallel lane bank.
- Presents the bank as one flat bus with a one-cycle Valid_Out pulse, matching the tree's Valid_In semantics.
- Supports early frame termination: unfilled lanes are padded with +0.0, the additive identity.

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_lane_collector_if.sv | 32 +++
 rtl/fp_lane_collector_bank.sv | 53 +++++
 rtl/fp_lane_collector.sv | 135 +++++++++++++
 tb/tb_fp_lane_collector.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// ============================================================================
// Module  : fp_pkg
// Brief   : Shared FP32 constants, lane-slice helper and collector state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Bit offset of a lane within a flat lane bank.
    function automatic int lane_offset(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_lane_collector_if.sv
// ============================================================================
// Module  : fp_lane_collector_if
// Brief   : Serial-in / lane-bank-out bus of the FP lane collector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_lane_collector_if #(
    parameter int N_CH   = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(N_CH)
);
    logic [DATA_W-1:0]      Data_In;
    logic                   Valid_In;
    logic                   Last_In;
    logic                   Ready_In;
    logic [N_CH*DATA_W-1:0] Data_Out;
    logic                   Valid_Out;
    logic [CNT_W:0]         Frame_Len;

    modport master (
        output Data_In, Valid_In, Last_In,
        input  Ready_In, Data_Out, Valid_Out, Frame_Len
    );

    modport slave (
        input  Data_In, Valid_In, Last_In,
        output Ready_In, Data_Out, Valid_Out, Frame_Len
    );
endinterface

`default_nettype wire

// File: rtl/fp_lane_collector_bank.sv
// ============================================================================
// Module  : fp_lane_bank
// Brief   : Fill-lane register bank with per-lane write, sync clear and
//           parallel copy (with final-word bypass) into the output register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_lane_bank
    import fp_pkg::*;
#(
    parameter int N_CH   = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(N_CH)
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   clr,
    input  wire logic                   wr_en,
    input  wire logic [CNT_W-1:0]       wr_idx,
    input  wire logic [DATA_W-1:0]      wr_data,
    input  wire logic                   copy_en,
    output logic      [N_CH*DATA_W-1:0] bank_out
);

    logic [N_CH*DATA_W-1:0] r_fill;
    logic [N_CH*DATA_W-1:0] r_out;

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_CH; k++) begin
            // Clear wins over write so the word that closes a frame never
            // leaks into the next one.
            if (rst || clr) begin
                r_fill[lane_offset(k, DATA_W) +: DATA_W] <= DATA_W'(FP_POS_ZERO);
            end else if (wr_en && (wr_idx == CNT_W'(k))) begin
                r_fill[lane_offset(k, DATA_W) +: DATA_W] <= wr_data;
            end

            if (rst) begin
                r_out[lane_offset(k, DATA_W) +: DATA_W] <= DATA_W'(FP_POS_ZERO);
            end else if (copy_en) begin
                r_out[lane_offset(k, DATA_W) +: DATA_W] <=
                    (wr_en && (wr_idx == CNT_W'(k))) ? wr_data
                                                     : r_fill[lane_offset(k, DATA_W) +: DATA_W];
            end
        end
    end

    assign bank_out = r_out;

endmodule

`default_nettype wire

// File: rtl/fp_lane_collector.sv
// ============================================================================
// Module  : fp_lane_collector
// Brief   : Packs a serial FP32 stream into N_CH-lane frames, zero-padding
//           early-terminated frames. Option: FP_LANE_COLLECTOR_NOSTALL_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_lane_collector
    import fp_pkg::*;
#(
    parameter int N_CH   = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(N_CH)
) (
    input wire logic            clk,
    input wire logic            rst,
    fp_lane_collector_if.slave  bus
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic [CNT_W:0]   r_frame_len;

    logic w_ready;
    logic w_accept;
    logic w_final;
    logic w_bank_clr;
    logic w_copy;

    assign w_accept = bus.Valid_In && w_ready;
    assign w_final  = w_accept && (bus.Last_In || (r_cnt == CNT_W'(N_CH - 1)));

`ifdef FP_LANE_COLLECTOR_NOSTALL_EN

    // Final word bypasses straight into the output register, so no stall.
    assign w_ready    = 1'b1;
    assign w_bank_clr = w_final;
    assign w_copy     = w_final;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_frame_len <= '0;
        end else begin
            r_valid <= w_final;
            if (w_final) begin
                r_cnt       <= '0;
                r_frame_len <= {1'b0, r_cnt} + (CNT_W+1)'(1);
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`else

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CNT_W:0] r_len;

    assign w_ready = (r_state == FILL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bank_clr  = 1'b0;
        w_copy      = 1'b0;
        case (r_state)
            FILL: begin
                if (w_final) begin
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                w_bank_clr  = 1'b1;
                w_copy      = 1'b1;
                w_state_nxt = FILL;
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_len       <= '0;
            r_valid     <= 1'b0;
            r_frame_len <= '0;
        end else begin
            r_valid <= (r_state == EMIT);
            if (r_state == EMIT) begin
                r_cnt       <= '0;
                r_frame_len <= r_len;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_final) begin
                    r_len <= {1'b0, r_cnt} + (CNT_W+1)'(1);
                end
            end
        end
    end

`endif

    fp_lane_bank #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_bank_clr),
        .wr_en    (w_accept),
        .wr_idx   (r_cnt),
        .wr_data  (bus.Data_In),
        .copy_en  (w_copy),
        .bank_out (bus.Data_Out)
    );

    assign bus.Ready_In  = w_ready;
    assign bus.Valid_Out = r_valid;
    assign bus.Frame_Len = r_frame_len;

endmodule

`default_nettype wire

// File: tb/tb_fp_lane_collector.sv
// ============================================================================
// Module  : tb_fp_lane_collector
// Brief   : Scoreboard bench for fp_lane_collector (base or NOSTALL build).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_lane_collector;
    import fp_pkg::*;

    localparam int N_CH   = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(N_CH);
    localparam int PERIOD = 10;
`ifdef FP_LANE_COLLECTOR_NOSTALL_EN
    localparam int LAT     = 5;   // accept edge to the next negedge sample
    localparam int SPACING = 32;
`else
    localparam int LAT     = 15;  // accept edge, EMIT cycle, then sample
    localparam int SPACING = 33;
`endif

    typedef struct {
        logic [N_CH*DATA_W-1:0] data;
        int                     len;
        time                    t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fp_lane_collector_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

    fp_lane_collector #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #(PERIOD/2) clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    logic [DATA_W-1:0] m_lane [N_CH];
    int                m_cnt = 0;

    logic contig    = 1'b0;
    logic have_prev = 1'b0;
    time  prev_vt   = 0;
    logic prev_valid = 1'b0;
    int   low_run   = 0;
    int   low_total = 0;

    task automatic chk(input string name, input logic ok,
                       input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N_CH; i++) m_lane[i] = '0;
        m_cnt = 0;
    endtask

    // Drive one word and hold it until the collector accepts it.
    task automatic send(input logic [DATA_W-1:0] d, input logic last);
        int   guard;
        logic acc;
        exp_t e;
        guard = 0;
        @(negedge clk);
        bus.Data_In  = d;
        bus.Valid_In = 1'b1;
        bus.Last_In  = last;
        forever begin
            acc = bus.Ready_In;
            @(posedge clk);
            if (acc) break;
            guard++;
            if (guard > 50) begin
                chk("accept_timeout", 1'b0, 64'(guard), 64'd50);
                return;
            end
            @(negedge clk);
        end
        m_lane[m_cnt] = d;
        m_cnt++;
        if (last || m_cnt == N_CH) begin
            for (int i = 0; i < N_CH; i++) e.data[i*DATA_W +: DATA_W] = m_lane[i];
            e.len = m_cnt;
            e.t   = $time + LAT;
            sbq.push_back(e);
            model_clear();
        end
    endtask

    task automatic idle(input int n, input logic noise);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.Valid_In = 1'b0;
            bus.Last_In  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.Data_In  = $urandom;
        end
    endtask

    // Monitor: pops the scoreboard whenever a frame is presented.
    always @(negedge clk) begin
        exp_t e;
        int   bad;
        if (bus.Valid_Out) begin
            if (sbq.size() == 0) begin
                chk("unexpected_frame", 1'b0, 64'd1, 64'd0);
            end else begin
                e   = sbq.pop_front();
                bad = -1;
                for (int i = 0; i < N_CH; i++)
                    if (bad < 0 && bus.Data_Out[i*DATA_W +: DATA_W] !== e.data[i*DATA_W +: DATA_W])
                        bad = i;
                if (bad < 0)
                    chk("lanes", 1'b1, 64'd0, 64'd0);
                else
                    chk($sformatf("lane%0d", bad), 1'b0,
                        64'(bus.Data_Out[bad*DATA_W +: DATA_W]), 64'(e.data[bad*DATA_W +: DATA_W]));
                chk("frame_len", bus.Frame_Len == (CNT_W+1)'(e.len), 64'(bus.Frame_Len), 64'(e.len));
                chk("latency_time", $time == e.t, 64'($time), 64'(e.t));
            end
            chk("valid_single_cycle", !prev_valid, 64'(prev_valid), 64'd0);
            if (contig) begin
                if (have_prev)
                    chk("spacing", ($time - prev_vt) == SPACING*PERIOD,
                        64'($time - prev_vt), 64'(SPACING*PERIOD));
                have_prev = 1'b1;
                prev_vt   = $time;
            end
        end
        prev_valid = bus.Valid_Out;
        if (!rst) begin
            if (!bus.Ready_In) begin
                low_run++;
                low_total++;
            end else if (low_run > 0) begin
                chk("ready_low_run", low_run == 1, 64'(low_run), 64'd1);
                low_run = 0;
            end
        end
    end

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        logic [DATA_W-1:0] short_vals [5];
        short_vals[0] = 32'h3F800000;
        short_vals[1] = 32'h40000000;
        short_vals[2] = 32'h40400000;
        short_vals[3] = 32'h40800000;
        short_vals[4] = 32'h40A00000;

        bus.Data_In  = '0;
        bus.Valid_In = 1'b0;
        bus.Last_In  = 1'b0;
        model_clear();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", bus.Ready_In == 1'b1, 64'(bus.Ready_In), 64'd1);
        chk("reset_valid", bus.Valid_Out == 1'b0, 64'(bus.Valid_Out), 64'd0);
        chk("reset_len", bus.Frame_Len == '0, 64'(bus.Frame_Len), 64'd0);
        chk("reset_data", bus.Data_Out == '0, bus.Data_Out[63:0], 64'd0);

        // Three contiguous full frames of 1.0.
        contig = 1'b1;
        for (int i = 0; i < 3*N_CH; i++) send(32'h3F800000, 1'b0);
        idle(4, 1'b0);
        contig = 1'b0;

        // Short frame 1.0..5.0 with Last_In on the fifth word.
        for (int i = 0; i < 5; i++) send(short_vals[i], i == 4);
        idle(3, 1'b1);

        // Two single-word frames back to back, then one with bit-exact NaN.
        send(32'hC0400000, 1'b1);
        send(32'hC0400000, 1'b1);
        send(32'h7FC00001, 1'b1);
        idle(3, 1'b0);

        // Partial frame of 17 words abandoned by reset, then a full 2.0 frame.
        for (int i = 0; i < 17; i++) send(32'h3F800000 + i, 1'b0);
        @(negedge clk);
        bus.Valid_In = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < N_CH; i++) send(32'h40000000, 1'b0);
        idle(3, 1'b0);

        // Random-length frames with gaps, random data and stray Last_In.
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(1, N_CH);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) < 7) idle($urandom_range(1, 3), 1'b1);
                send($urandom, (i == len - 1) && (len < N_CH || $urandom_range(0, 1) == 1));
            end
        end
        idle(10, 1'b0);

        chk("scoreboard_drained", sbq.size() == 0, 64'(sbq.size()), 64'd0);
`ifdef FP_LANE_COLLECTOR_NOSTALL_EN
        chk("ready_never_low", low_total == 0, 64'(low_total), 64'd0);
`else
        chk("ready_low_seen", low_total > 0, 64'(low_total), 64'd1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
